// File: rtl/rom_resp_pkg.sv
// Shared types and defaults for the ROM responder model.
// FSM state encoding, access counter type and default widths.
package rom_resp_pkg;

   localparam int DEF_ADDR_WIDTH = 12;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int CNT_W          = 4;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DRIVE  = 2'd2
   } rom_resp_state_t;

endpackage

// File: rtl/rom_resp_mem.sv
// Single-port ROM image with synchronous read and a backdoor
// write port; contents are never reset.
module rom_resp_mem #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/rom_responder.sv
// Cycle-accurate parallel ROM responder: CE/OE qualified reads with
// fixed access latency, write-strobe error flag and read statistics.
module rom_responder
   import rom_resp_pkg::*;
#(
   parameter int ROM_ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int ROM_DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ACCESS_CYCLES  = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [ROM_ADDR_WIDTH-1:0] rom_rd_addr,
   input  logic                      CE_bar,
   input  logic                      OE_bar,
   input  logic                      WE_bar,
   output logic [ROM_DATA_WIDTH-1:0] rom_rd_data,
   output logic                      rom_data_vld,
   input  logic                      load_en,
   input  logic [ROM_ADDR_WIDTH-1:0] load_addr,
   input  logic [ROM_DATA_WIDTH-1:0] load_data,
   output logic                      load_rej,
   output logic                      we_err,
   output logic [31:0]               rd_count
);

   if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_cycles
      $error("rom_responder: ACCESS_CYCLES out of range 1..15");
   end

   localparam cnt_t CNT_LOAD = cnt_t'(ACCESS_CYCLES - 1);

   rom_resp_state_t           state_q, state_d;
   cnt_t                      cnt_q, cnt_d;
   logic [ROM_ADDR_WIDTH-1:0] lat_q, lat_d;
   logic [ROM_DATA_WIDTH-1:0] data_d;
   logic [ROM_DATA_WIDTH-1:0] mem_q;
   logic                      vld_d;
   logic                      inc;
   logic                      sel;
   logic                      addr_chg;
   logic                      mem_we;

   assign sel      = ~CE_bar & ~OE_bar;
   assign addr_chg = rom_rd_addr != lat_q;
   assign mem_we   = load_en & CE_bar;

   // While selected the live address equals the latched one unless it
   // is being relatched, so the array can always look up the live address.
   rom_resp_mem #(
      .ADDR_WIDTH (ROM_ADDR_WIDTH),
      .DATA_WIDTH (ROM_DATA_WIDTH)
   ) u_mem (
      .clk     (clk),
      .rd_addr (rom_rd_addr),
      .rd_data (mem_q),
      .wr_en   (mem_we),
      .wr_addr (load_addr),
      .wr_data (load_data)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lat_d   = lat_q;
      data_d  = '0;
      vld_d   = 1'b0;
      inc     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (sel) begin
               lat_d   = rom_rd_addr;
               cnt_d   = CNT_LOAD;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (!sel) begin
               state_d = IDLE;
            end else if (addr_chg) begin
               lat_d = rom_rd_addr;
               cnt_d = CNT_LOAD;
            end else if (cnt_q == '0) begin
               data_d  = mem_q;
               vld_d   = 1'b1;
               inc     = 1'b1;
               state_d = DRIVE;
            end else begin
               cnt_d = cnt_q - cnt_t'(1);
            end
         end
         DRIVE: begin
            if (!sel) begin
               state_d = IDLE;
            end else if (addr_chg) begin
               lat_d   = rom_rd_addr;
               cnt_d   = CNT_LOAD;
               state_d = ACCESS;
            end else begin
               data_d = rom_rd_data;
               vld_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         lat_q        <= '0;
         rom_rd_data  <= '0;
         rom_data_vld <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         lat_q        <= lat_d;
         rom_rd_data  <= data_d;
         rom_data_vld <= vld_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         load_rej <= 1'b0;
      end else begin
         load_rej <= load_en & ~CE_bar;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         we_err <= 1'b0;
      end else if (~CE_bar & ~WE_bar) begin
         we_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_count <= '0;
      end else if (inc) begin
         rd_count <= rd_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_rom_responder.sv
// Directed bench for rom_responder (ACCESS_CYCLES=3 and =1 instances).
module tb_rom_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] rom_rd_addr;
   logic        CE_bar, OE_bar, WE_bar;
   logic        load_en;
   logic [11:0] load_addr;
   logic [31:0] load_data;

   logic [31:0] rom_rd_data, rom_rd_data1;
   logic        rom_data_vld, rom_data_vld1;
   logic        load_rej, load_rej1;
   logic        we_err, we_err1;
   logic [31:0] rd_count, rd_count1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rom_responder #(
      .ROM_ADDR_WIDTH (12),
      .ROM_DATA_WIDTH (32),
      .ACCESS_CYCLES  (3)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rom_rd_addr  (rom_rd_addr),
      .CE_bar       (CE_bar),
      .OE_bar       (OE_bar),
      .WE_bar       (WE_bar),
      .rom_rd_data  (rom_rd_data),
      .rom_data_vld (rom_data_vld),
      .load_en      (load_en),
      .load_addr    (load_addr),
      .load_data    (load_data),
      .load_rej     (load_rej),
      .we_err       (we_err),
      .rd_count     (rd_count)
   );

   rom_responder #(
      .ROM_ADDR_WIDTH (12),
      .ROM_DATA_WIDTH (32),
      .ACCESS_CYCLES  (1)
   ) dut1 (
      .clk          (clk),
      .reset        (reset),
      .rom_rd_addr  (rom_rd_addr),
      .CE_bar       (CE_bar),
      .OE_bar       (OE_bar),
      .WE_bar       (WE_bar),
      .rom_rd_data  (rom_rd_data1),
      .rom_data_vld (rom_data_vld1),
      .load_en      (load_en),
      .load_addr    (load_addr),
      .load_data    (load_data),
      .load_rej     (load_rej1),
      .we_err       (we_err1),
      .rd_count     (rd_count1)
   );

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [11:0] a, input logic [31:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      step(1);
      load_en   = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      rom_rd_addr = '0;
      CE_bar      = 1'b1;
      OE_bar      = 1'b1;
      WE_bar      = 1'b1;
      load_en     = 1'b0;
      load_addr   = '0;
      load_data   = '0;
      step(2);
      reset = 1'b0;
      step(1);

      chk("rst_data", rom_rd_data, 32'h0);
      chk("rst_vld", {31'b0, rom_data_vld}, 32'h0);
      chk("rst_rej", {31'b0, load_rej}, 32'h0);
      chk("rst_weerr", {31'b0, we_err}, 32'h0);
      chk("rst_count", rd_count, 32'h0);

      load(12'h010, 32'hDEAD_BEEF);
      load(12'h011, 32'h1234_5678);
      load(12'h020, 32'hCAFE_F00D);
      chk("load_ok_no_rej", {31'b0, load_rej}, 32'h0);

      // basic read at 0x010
      rom_rd_addr = 12'h010;
      CE_bar = 1'b0;
      OE_bar = 1'b0;
      step(1);
      chk("r1_n0_vld", {31'b0, rom_data_vld}, 32'h0);
      chk("ac1_n0_vld", {31'b0, rom_data_vld1}, 32'h0);
      step(1);
      chk("r1_n1_vld", {31'b0, rom_data_vld}, 32'h0);
      chk("ac1_n1_vld", {31'b0, rom_data_vld1}, 32'h1);
      chk("ac1_n1_data", rom_rd_data1, 32'hDEAD_BEEF);
      chk("ac1_n1_count", rd_count1, 32'h1);
      step(1);
      chk("r1_n2_vld", {31'b0, rom_data_vld}, 32'h0);
      chk("r1_n2_data", rom_rd_data, 32'h0);
      step(1);
      chk("r1_n3_vld", {31'b0, rom_data_vld}, 32'h1);
      chk("r1_n3_data", rom_rd_data, 32'hDEAD_BEEF);
      chk("r1_n3_count", rd_count, 32'h1);
      step(2);
      chk("r1_hold_vld", {31'b0, rom_data_vld}, 32'h1);
      chk("r1_hold_data", rom_rd_data, 32'hDEAD_BEEF);
      chk("r1_hold_count", rd_count, 32'h1);

      CE_bar = 1'b1;
      step(1);
      chk("desel_vld", {31'b0, rom_data_vld}, 32'h0);
      chk("desel_data", rom_rd_data, 32'h0);

      // address change mid-access: aborted access is not counted
      rom_rd_addr = 12'h010;
      CE_bar = 1'b0;
      step(2);
      rom_rd_addr = 12'h011;
      step(1);
      chk("chg_e12_vld", {31'b0, rom_data_vld}, 32'h0);
      step(2);
      chk("chg_e14_vld", {31'b0, rom_data_vld}, 32'h0);
      chk("chg_e14_count", rd_count, 32'h1);
      step(1);
      chk("chg_e15_vld", {31'b0, rom_data_vld}, 32'h1);
      chk("chg_e15_data", rom_rd_data, 32'h1234_5678);
      chk("chg_e15_count", rd_count, 32'h2);

      // address change while driving
      rom_rd_addr = 12'h020;
      step(1);
      chk("drv_chg_vld", {31'b0, rom_data_vld}, 32'h0);
      chk("drv_chg_data", rom_rd_data, 32'h0);
      step(3);
      chk("drv_chg_new", rom_rd_data, 32'hCAFE_F00D);
      chk("drv_chg_count", rd_count, 32'h3);

      OE_bar = 1'b1;
      step(1);
      chk("oe_desel_vld", {31'b0, rom_data_vld}, 32'h0);

      // rejected backdoor load while CE_bar is low
      load_en   = 1'b1;
      load_addr = 12'h010;
      load_data = 32'hBAD0_BAD0;
      step(1);
      load_en = 1'b0;
      chk("rej_pulse", {31'b0, load_rej}, 32'h1);
      step(1);
      chk("rej_clear", {31'b0, load_rej}, 32'h0);
      rom_rd_addr = 12'h010;
      OE_bar = 1'b0;
      step(4);
      chk("rej_old_data", rom_rd_data, 32'hDEAD_BEEF);
      chk("rej_count", rd_count, 32'h4);
      CE_bar = 1'b1;
      OE_bar = 1'b1;
      step(1);

      // write strobe error is sticky and harmless
      CE_bar = 1'b0;
      WE_bar = 1'b0;
      step(1);
      CE_bar = 1'b1;
      WE_bar = 1'b1;
      chk("we_err_set", {31'b0, we_err}, 32'h1);
      step(3);
      chk("we_err_sticky", {31'b0, we_err}, 32'h1);
      rom_rd_addr = 12'h011;
      CE_bar = 1'b0;
      OE_bar = 1'b0;
      step(4);
      chk("we_err_mem", rom_rd_data, 32'h1234_5678);
      chk("we_err_count", rd_count, 32'h5);
      CE_bar = 1'b1;
      OE_bar = 1'b1;
      step(1);

      // reset in the middle of an access
      rom_rd_addr = 12'h020;
      CE_bar = 1'b0;
      OE_bar = 1'b0;
      step(1);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      chk("mid_rst_vld", {31'b0, rom_data_vld}, 32'h0);
      chk("mid_rst_data", rom_rd_data, 32'h0);
      chk("mid_rst_count", rd_count, 32'h0);
      chk("mid_rst_weerr", {31'b0, we_err}, 32'h0);
      step(2);
      chk("post_rst_vld", {31'b0, rom_data_vld}, 32'h0);
      chk("post_rst_cnt0", rd_count, 32'h0);
      step(2);
      chk("post_rst_data", rom_rd_data, 32'hCAFE_F00D);
      chk("post_rst_count", rd_count, 32'h1);
      CE_bar = 1'b1;
      OE_bar = 1'b1;
      step(1);

      // counter wrap plus load visible on the very next edge
      force dut.rd_count = 32'hFFFF_FFFF;
      #1;
      release dut.rd_count;
      load(12'h030, 32'h0BAD_CAFE);
      rom_rd_addr = 12'h030;
      CE_bar = 1'b0;
      OE_bar = 1'b0;
      step(4);
      chk("wrap_data", rom_rd_data, 32'h0BAD_CAFE);
      chk("wrap_count", rd_count, 32'h0);
      CE_bar = 1'b1;
      OE_bar = 1'b1;
      step(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
